// File: rtl/serial_word_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_word_rx_pkg
// Shared definitions for the serial word receiver:
//   - receiver FSM state encoding (legacy constants plus a typed enum)
//   - serial line levels for the start, stop and idle conditions
//   - cnt_width(): bit-counter width needed to count WIDTH data bits
// -----------------------------------------------------------------------------
package serial_word_rx_pkg;

    // Legacy state codes. The enum below is built on these values so that
    // waveforms and older tooling that decode the raw 2-bit code still work.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_e;

    // Serial line levels
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Smallest counter width that can index WIDTH data bits (never below 1).
    function automatic int cnt_width(input int width);
        int res;
        res = 1;
        for (int i = 31; i >= 1; i--) begin
            if ((32'd1 << i) >= width) begin
                res = i;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_word_rx_word_hold_reg.sv
// -----------------------------------------------------------------------------
// word_hold_reg
// One-deep valid/ready output register for the serial word receiver.
// Owns the delivery, consume and overrun decisions.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   i_load     in   a completed, well-framed word is offered this cycle
//   i_data     in   offered word
//   i_perr     in   parity mismatch flag travelling with the offered word
//   i_ready    in   consumer accepts o_data this cycle
//   o_data     out  held word (keeps its value after being consumed)
//   o_valid    out  o_data holds an unconsumed word
//   o_perr     out  parity flag of the held word
//   o_overrun  out  one-cycle pulse: offered word dropped, register was full
// -----------------------------------------------------------------------------
module word_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_perr,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_perr,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_perr;
    logic             r_overrun;

    // Load / consume / overrun decision for the holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_load) begin
                // A consume in the same cycle frees the slot, so the new word
                // replaces the departing one without loss.
                if (!r_valid || i_ready) begin
                    r_data  <= i_data;
                    r_perr  <= i_perr;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_perr    = r_perr;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_word_rx.sv
// -----------------------------------------------------------------------------
// serial_word_rx
// Deframes a start / data (LSB first) / optional parity / stop serial stream,
// sampled only on sin_valid strobes, into parallel words presented through a
// one-deep valid/ready register.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   sin_valid   in   bit strobe; sin is sampled only when this is 1
//   sin         in   serial data, idle level 1
//   dout        out  received word
//   dout_valid  out  dout holds an unconsumed word
//   dout_ready  in   consumer accepts dout this cycle
//   parity_err  out  parity mismatch of the word in dout (held with dout)
//   frame_err   out  one-cycle pulse: stop bit sampled as 0
//   overrun     out  one-cycle pulse: good word dropped, output register full
//   busy        out  receiver is inside a frame (state != IDLE)
// -----------------------------------------------------------------------------
module serial_word_rx
    import serial_word_rx_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    // Mismatch between a received parity bit and the parity of the word.
    function automatic logic parity_mismatch(input logic i_bit,
                                             input logic [WIDTH-1:0] i_word);
        logic w_exp;
        w_exp = ODD_PARITY ? ~^i_word : ^i_word;
        return (i_bit != w_exp);
    endfunction

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             r_par_err;
    logic             w_par_err_nxt;
    logic             w_deliver;
    logic             w_frame_bad;
    logic             r_frame_err;
    logic             w_perr_out;

    // Next-state, counter, shift register and frame-end decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_par_err_nxt = r_par_err;
        w_deliver     = 1'b0;
        w_frame_bad   = 1'b0;
        if (sin_valid) begin
            case (r_state)
                IDLE: begin
                    if (sin == START_BIT) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shifting right into the MSB leaves
                    // the word in natural order after WIDTH strobes.
                    w_shift_nxt = {sin, r_shift[WIDTH-1:1]};
                    w_cnt_nxt   = r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = PARITY_EN ? PARITY : STOP;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
                PARITY: begin
                    w_par_err_nxt = parity_mismatch(sin, r_shift);
                    w_state_nxt   = STOP;
                end
                STOP: begin
                    if (sin == STOP_BIT) begin
                        w_deliver = 1'b1;
                    end else begin
                        w_frame_bad = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Receiver state registers and the framing-error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_par_err   <= w_par_err_nxt;
            r_frame_err <= w_frame_bad;
        end
    end

    assign w_perr_out = PARITY_EN ? r_par_err : 1'b0;

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_deliver),
        .i_data    (r_shift),
        .i_perr    (w_perr_out),
        .i_ready   (dout_ready),
        .o_data    (dout),
        .o_valid   (dout_valid),
        .o_perr    (parity_err),
        .o_overrun (overrun)
    );

    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Downstream consumer of the team's universal shift register serial output (PISO/SISO mode bit stream).
- Deframes a start/data/parity/stop serial stream, sampled only on a bit strobe, into parallel words.
- Presents each word through a one-deep valid/ready output register.
- Flags parity, framing and overrun errors.

Parameters:
- WIDTH, 4, data bits per frame (>=2).
- PARITY_EN, 1, 1 = frame carries a parity bit after the data; 0 = no parity bit.
- ODD_PARITY, 0, 0 = even parity (expected bit = ^data); 1 = odd parity (expected bit = ~^data).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sin_valid  in  1  bit strobe; sin is sampled only on edges where this is 1.
- sin  in  1  serial data; idle line is 1.
- dout  out  WIDTH  received word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout this cycle.
- parity_err  out  1  parity mismatch for the word currently in dout; held with dout.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: completed word dropped because the output register was full.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1, async): state=IDLE, bit counter=0, shift reg=0, dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- Reset mid-frame discards the partial frame with no error pulse.
- Frame format: start bit 0, WIDTH data bits LSB first, optional parity bit, stop bit 1.
- Edges with sin_valid=0 leave state, counter and shift reg unchanged. Gaps of any length are legal.
- FSM:
  - IDLE: sin_valid & sin==0 -> DATA, cnt=0. A 1 sampled in IDLE is ignored.
  - DATA: each strobe shifts sin into the shift reg MSB (right shift) and increments cnt. On the strobe with cnt==WIDTH-1: go to PARITY if PARITY_EN, else STOP.
  - PARITY: on strobe, capture the parity bit and compute the mismatch against the shift reg; -> STOP.
  - STOP, strobe with sin==1 (good frame): deliver the word (see delivery rules); -> IDLE.
  - STOP, strobe with sin==0 (framing error): discard the word; frame_err=1 for exactly the next cycle; dout and dout_valid unchanged; -> IDLE.
- A new start bit is accepted on the strobe immediately after the stop-bit strobe. No idle gap is required.
- Delivery is evaluated on the stop-bit edge:
  - dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle: dout <= shift reg, parity_err <= mismatch (0 if !PARITY_EN), dout_valid <= 1. A simultaneous consume and deliver never drops a word and never pulses overrun.
  - dout_valid=1 with dout_ready=0: new word dropped; dout and parity_err held; overrun=1 for one cycle.
- Consume: dout_valid & dout_ready with no simultaneous delivery -> dout_valid <= 0. dout keeps its last value.
- Latency: dout_valid rises the cycle after the stop-bit sampling edge.
- dout_ready is ignored while dout_valid=0.
- All outputs are registered except busy, which is decoded from the state.

Decomposition:
- Shared package:
  - state enum {IDLE, DATA, PARITY, STOP}
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1
  - bit-counter width function clog2(WIDTH)
- One natural sub-module: word_hold_reg. It is the one-deep valid/ready output register and owns the delivery/consume/overrun logic. The FSM and shift reg stay in the top module.

Test Plan (WIDTH=4, PARITY_EN=1, ODD_PARITY=0 unless stated):
- Strobe stream 0,1,0,1,1,1,1 with dout_ready=1 -> dout=4'hD, parity_err=0, dout_valid high 1 cycle after the 7th strobe, busy low after it.
- Same stream with parity bit 0 (0,1,0,1,1,0,1) -> dout=4'hD, parity_err=1.
- Stream 0,1,0,1,1,1,0 -> no dout_valid; frame_err pulses exactly 1 cycle; next frame for 4'h3 (0,1,1,0,0,0,1) decodes dout=4'h3.
- dout_ready=0 across frames 4'hD then 4'h3 -> dout stays 4'hD, one overrun pulse. Raise dout_ready -> dout_valid drops next cycle. Also: a stop edge coinciding with dout_ready=1 -> dout updates with no overrun.
- Frame 4'hA with random 0-5 cycle gaps between strobes, plus a back-to-back frame 4'h5 -> dout 4'hA then 4'h5, no errors.
- Assert rst after 2 data bits of a frame -> all outputs 0, busy=0. Then frame 4'h6 (0,0,1,1,0,0,1) -> dout=4'h6, parity_err=0. Repeat 4'h6 with PARITY_EN=0 (0,0,1,1,0,1) -> dout=4'h6.
